hs_slave_fifo: RTL

HS_SLAVE_FIFO -- requirements
Module: hs_slave_fifo

---
 rtl/hs_slave_fifo.sv | 62 ++++++
 1 files changed

// File: rtl/hs_slave_fifo.sv
// hs_slave_fifo: first-word-fall-through buffer with an ON/OFF throttled
// upstream ready and a sticky flag for upstream stall-protocol violations.
module hs_slave_fifo #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int ON_CYC  = 3,
    parameter int OFF_CYC = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    throttle_en,
    input  logic                    S_valid,
    input  logic [DATA_W-1:0]       S_data,
    output logic                    S_ready,
    output logic                    M_valid,
    output logic [DATA_W-1:0]       M_data,
    input  logic                    M_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    proto_err
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LAST = ON_CYC + OFF_CYC - 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [7:0]        phase;
    logic              rdy_en, allow, push, pop, stall_q;
    logic [DATA_W-1:0] stall_data;

    assign allow   = !throttle_en || OFF_CYC == 0 || int'(phase) < ON_CYC;
    assign S_ready = rdy_en && level < (AW+1)'(DEPTH) && allow;
    assign M_valid = level != '0;
    assign M_data  = mem[rd_ptr];
    assign push    = S_valid && S_ready;
    assign pop     = M_valid && M_ready;

    always_ff @(posedge clk) if (push) mem[wr_ptr] <= S_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            phase      <= '0;
            stall_q    <= 1'b0;
            stall_data <= '0;
            proto_err  <= 1'b0;
        end else begin
            rdy_en     <= 1'b1;
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
            level      <= level + (AW+1)'(push) - (AW+1)'(pop);
            if (!throttle_en) phase <= '0;
            else if (rdy_en) phase <= int'(phase) >= LAST ? '0 : phase + 8'd1;
            // a stalled offer must be repeated unchanged on the following edge
            stall_q    <= S_valid && !S_ready;
            stall_data <= S_data;
            if (stall_q && (!S_valid || S_data != stall_data)) proto_err <= 1'b1;
        end
    end
endmodule
